time_cnt_resync: RTL and testbench



---
 rtl/time_cnt_resync_if.sv | 27 ++
 rtl/time_cnt_resync.sv | 173 +++++++++++++++++
 tb/tb_time_cnt_resync.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/time_cnt_resync_if.sv
// time_cnt_resync_if: bundles the system-time input, the per-channel cycle and
// counter arrays and the sweep status into one bus between the time source,
// the resync block and the PWM generators.
interface time_cnt_resync_if #(
    parameter int WIDTH      = 13,
    parameter int DEPTH      = 249,
    parameter int TIME_WIDTH = 64
);
    localparam int CH_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [TIME_WIDTH-1:0] sysTime;
    logic [WIDTH-1:0]      cycle   [0:DEPTH-1];
    logic                  resync;
    logic [WIDTH-1:0]      timeCnt [0:DEPTH-1];
    logic                  sweepDone;
    logic [CH_W-1:0]       busyCh;

    modport master (
        output sysTime, cycle, resync,
        input  timeCnt, sweepDone, busyCh
    );

    modport slave (
        input  sysTime, cycle, resync,
        output timeCnt, sweepDone, busyCh
    );
endinterface

// File: rtl/time_cnt_resync.sv
// time_cnt_resync: one free-running modulo-T counter per channel, periodically
// re-aligned to SYS_TIME mod T by a single shared restoring divider that visits
// the channels round-robin. Each slot lasts TIME_WIDTH+1 cycles: one sampling
// edge, TIME_WIDTH divider steps, and the write edge which also samples the
// next channel.
module time_cnt_resync #(
    parameter int WIDTH      = 13,
    parameter int DEPTH      = 249,
    parameter int TIME_WIDTH = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    time_cnt_resync_if.slave     bus
);
    localparam int L      = TIME_WIDTH + 1;
    localparam int STEP_W = $clog2(L + 1);
    localparam int CH_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [STEP_W-1:0]     LAST_STEP = STEP_W'(L);
    localparam logic [CH_W-1:0]       LAST_CH   = CH_W'(DEPTH - 1);
    localparam logic [TIME_WIDTH-1:0] LEAD      = TIME_WIDTH'(L);

    typedef enum logic {
        ST_START,
        ST_DIVIDE
    } state_t;

    state_t                stateQ, stateD;
    logic [STEP_W-1:0]     stepQ, stepD;
    logic [CH_W-1:0]       chQ, chD;
    logic [TIME_WIDTH-1:0] dividendQ, dividendD;
    logic [WIDTH-1:0]      divisorQ, divisorD;
    logic [WIDTH:0]        remQ, remD;
    logic                  pendQ, pendD;
    logic                  sweepDoneQ, sweepDoneD;
    logic [WIDTH-1:0]      timeCntQ [0:DEPTH-1];
    logic [WIDTH-1:0]      timeCntD [0:DEPTH-1];

    logic                  sampleNow;
    logic                  writeNow;
    logic [WIDTH+1:0]      shifted;
    logic [WIDTH-1:0]      writeVal;

    // One free-run step; the increment is one bit wider than the counter so
    // the compare cannot overflow, and a counter at or past T-1 (e.g. after
    // T shrank) wraps to 0. Periods of 0 and 1 pin the counter at 0.
    function automatic logic [WIDTH-1:0] freeRun(input logic [WIDTH-1:0] cnt,
                                                 input logic [WIDTH-1:0] t);
        logic [WIDTH:0] inc;
        inc = {1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1};
        if (t <= WIDTH'(1) || inc >= {1'b0, t}) begin
            return '0;
        end
        return inc[WIDTH-1:0];
    endfunction

    // Resync value: a remainder of 0 arriving while the counter sits at T-2
    // would skip T-1 and cut a PWM period short, so T-1 is loaded instead.
    function automatic logic [WIDTH-1:0] resyncValue(input logic [WIDTH-1:0] r,
                                                     input logic [WIDTH-1:0] cnt,
                                                     input logic [WIDTH-1:0] t);
        if (t <= WIDTH'(1)) begin
            return '0;
        end
        if (r == '0 && cnt == t - WIDTH'(2)) begin
            return t - WIDTH'(1);
        end
        return r;
    endfunction

    // Next-state logic: free-run every channel, step the divider, and on the
    // slot boundary (or a RESYNC request) write the finished channel and
    // sample the next one.
    always_comb begin
        stateD     = stateQ;
        stepD      = stepQ;
        chD        = chQ;
        dividendD  = dividendQ;
        divisorD   = divisorQ;
        remD       = remQ;
        pendD      = 1'b0;
        sweepDoneD = pendQ;
        sampleNow  = 1'b0;
        writeNow   = 1'b0;
        shifted    = {remQ, dividendQ[TIME_WIDTH-1]};
        writeVal   = resyncValue(remQ[WIDTH-1:0], timeCntQ[chQ], divisorQ);

        for (int i = 0; i < DEPTH; i++) begin
            timeCntD[i] = freeRun(timeCntQ[i], bus.cycle[i]);
        end

        if (bus.resync) begin
            sampleNow = 1'b1;
            chD       = '0;
        end else begin
            case (stateQ)
                ST_START: begin
                    sampleNow = 1'b1;
                    chD       = '0;
                end
                ST_DIVIDE: begin
                    if (stepQ == LAST_STEP) begin
                        writeNow  = 1'b1;
                        sampleNow = 1'b1;
                        chD       = (chQ == LAST_CH) ? '0 : chQ + CH_W'(1);
                    end else begin
                        if (shifted >= {2'b00, divisorQ}) begin
                            remD = (WIDTH + 1)'(shifted - {2'b00, divisorQ});
                        end else begin
                            remD = (WIDTH + 1)'(shifted);
                        end
                        dividendD = dividendQ << 1;
                        stepD     = stepQ + STEP_W'(1);
                    end
                end
                default: stateD = ST_START;
            endcase
        end

        if (writeNow) begin
            if (divisorQ != '0) begin
                timeCntD[chQ] = writeVal;
            end
            if (chQ == LAST_CH) begin
                pendD = 1'b1;
            end
        end

        if (sampleNow) begin
            stateD    = ST_DIVIDE;
            stepD     = STEP_W'(1);
            dividendD = bus.sysTime + LEAD;
            divisorD  = bus.cycle[chD];
            remD      = '0;
        end
    end

    // State register with synchronous reset clearing counters, divider and status.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stateQ     <= ST_START;
            stepQ      <= '0;
            chQ        <= '0;
            dividendQ  <= '0;
            divisorQ   <= '0;
            remQ       <= '0;
            pendQ      <= 1'b0;
            sweepDoneQ <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                timeCntQ[i] <= '0;
            end
        end else begin
            stateQ     <= stateD;
            stepQ      <= stepD;
            chQ        <= chD;
            dividendQ  <= dividendD;
            divisorQ   <= divisorD;
            remQ       <= remD;
            pendQ      <= pendD;
            sweepDoneQ <= sweepDoneD;
            for (int i = 0; i < DEPTH; i++) begin
                timeCntQ[i] <= timeCntD[i];
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_out
        assign bus.timeCnt[g] = timeCntQ[g];
    end

    assign bus.sweepDone = sweepDoneQ;
    assign bus.busyCh    = chQ;
endmodule

// File: tb/tb_time_cnt_resync.sv
// tb_time_cnt_resync: drives time_cnt_resync with directed and random stimulus
// and compares every cycle against a behavioural model through a scoreboard.
module tb_time_cnt_resync;
    localparam int WIDTH      = 13;
    localparam int DEPTH      = 4;
    localparam int TIME_WIDTH = 16;
    localparam int L          = TIME_WIDTH + 1;
    localparam int CH_W       = 2;
    localparam longint unsigned TIME_MOD = 64'd1 << TIME_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    time_cnt_resync_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIME_WIDTH(TIME_WIDTH)) bus ();

    time_cnt_resync #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIME_WIDTH(TIME_WIDTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [DEPTH*WIDTH-1:0] cnt;
        logic                   done;
        logic [CH_W-1:0]        busy;
    } exp_t;

    exp_t expQ[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   started     = 1'b0;

    longint unsigned sysVal;
    int unsigned     cycleVal [DEPTH];

    int unsigned     mCnt [DEPTH];
    bit              mActive;
    bit              mPend;
    bit              mDone;
    int              mCh;
    int              mAge;
    longint unsigned mT;
    longint unsigned mR;

    function automatic void startSlot(input int c, input longint unsigned s);
        mActive = 1'b1;
        mCh     = c;
        mAge    = 0;
        mT      = cycleVal[c];
        mR      = (mT != 0) ? ((s + L) % TIME_MOD) % mT : 0;
    endfunction

    function automatic void modelEdge(input bit r, input bit rs, input longint unsigned s);
        int unsigned nxt [DEPTH];
        int unsigned val;
        if (r) begin
            for (int i = 0; i < DEPTH; i++) mCnt[i] = 0;
            mActive = 1'b0;
            mPend   = 1'b0;
            mDone   = 1'b0;
            mCh     = 0;
            mAge    = 0;
            return;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (cycleVal[i] <= 1 || mCnt[i] + 1 >= cycleVal[i]) nxt[i] = 0;
            else nxt[i] = mCnt[i] + 1;
        end
        mDone = mPend;
        mPend = 1'b0;
        if (rs || !mActive) begin
            startSlot(0, s);
        end else begin
            mAge++;
            if (mAge == L) begin
                if (mT != 0) begin
                    if (mR == 0 && mT >= 2 && longint'(mCnt[mCh]) == longint'(mT) - 2) val = int'(mT - 1);
                    else val = int'(mR);
                    nxt[mCh] = val;
                end
                if (mCh == DEPTH - 1) mPend = 1'b1;
                startSlot((mCh + 1) % DEPTH, s);
            end
        end
        for (int i = 0; i < DEPTH; i++) mCnt[i] = nxt[i];
    endfunction

    task automatic applyStimulus(input bit r, input bit rs);
        exp_t e;
        @(negedge clk);
        rst         = r;
        bus.resync  = rs;
        bus.sysTime = sysVal[TIME_WIDTH-1:0];
        for (int i = 0; i < DEPTH; i++) bus.cycle[i] = cycleVal[i][WIDTH-1:0];
        modelEdge(r, rs, sysVal);
        for (int i = 0; i < DEPTH; i++) e.cnt[i*WIDTH +: WIDTH] = mCnt[i][WIDTH-1:0];
        e.done = mDone;
        e.busy = mCh[CH_W-1:0];
        expQ.push_back(e);
        started = 1'b1;
        sysVal  = (sysVal + 1) % TIME_MOD;
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s[%0d] actual %0d expected %0d at %0t", name, idx, got, want, $time);
        end
    endtask

    function automatic int unsigned pickCycle();
        case ($urandom_range(0, 9))
            0:       return 0;
            1:       return 1;
            2:       return 2;
            3:       return 3;
            4:       return 5;
            5:       return 100;
            6:       return 4096;
            7:       return 8191;
            default: return $urandom_range(2, 8191);
        endcase
    endfunction

    // Monitor: after every active edge pop the expected snapshot and compare.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                for (int i = 0; i < DEPTH; i++)
                    checkOutput("timeCnt", i, 64'(bus.timeCnt[i]), 64'(e.cnt[i*WIDTH +: WIDTH]));
                checkOutput("sweepDone", 0, 64'(bus.sweepDone), 64'(e.done));
                checkOutput("busyCh", 0, 64'(bus.busyCh), 64'(e.busy));
            end else if (started) begin
                miscompares++;
                $display("[TB] FAIL scoreboard underflow at %0t", $time);
            end
        end
    end

    // Driver: directed scenarios followed by a randomized soak.
    initial begin : driver
        int  guard;
        bit  wasWrite;
        bus.resync  = 1'b0;
        bus.sysTime = '0;
        cycleVal    = '{4096, 100, 3, 5000};
        for (int i = 0; i < DEPTH; i++) bus.cycle[i] = cycleVal[i][WIDTH-1:0];
        for (int i = 0; i < DEPTH; i++) mCnt[i] = 0;
        mActive = 1'b0; mPend = 1'b0; mDone = 1'b0; mCh = 0; mAge = 0; mT = 0; mR = 0;

        // Alignment from reset release at SYS_TIME = 10000
        sysVal = 9997;
        repeat (3) applyStimulus(1'b1, 1'b0);
        for (int k = 0; k < 18; k++) applyStimulus(1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("align0", 0, 64'(bus.timeCnt[0]), 64'd1825);
        for (int k = 18; k < 80; k++) applyStimulus(1'b0, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++)
            checkOutput("track", i, 64'(bus.timeCnt[i]),
                        64'(((sysVal + TIME_MOD - 1) % TIME_MOD) % cycleVal[i]));

        // Skip protection: +1 jump makes channel 1 see R=0 while at 98
        repeat (2) applyStimulus(1'b1, 1'b0);
        sysVal = 20097;
        for (int k = 0; k <= 102; k++) begin
            if (k == 50) sysVal = (sysVal + 1) % TIME_MOD;
            applyStimulus(1'b0, 1'b0);
        end
        @(posedge clk); #1;
        checkOutput("skipHold", 1, 64'(bus.timeCnt[1]), 64'd99);
        applyStimulus(1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("skipWrap", 1, 64'(bus.timeCnt[1]), 64'd0);

        // RESYNC five cycles into channel 2's slot
        guard = 0;
        while (!(mCh == 2 && mAge == 4) && guard < 200) begin
            applyStimulus(1'b0, 1'b0);
            guard++;
        end
        if (guard >= 200) begin
            miscompares++;
            $display("[TB] FAIL resyncSetup bound expired");
        end
        applyStimulus(1'b0, 1'b1);
        @(posedge clk); #1;
        checkOutput("resyncBusy", 0, 64'(bus.busyCh), 64'd0);
        repeat (100) applyStimulus(1'b0, 1'b0);

        // Reset during channel 1's divider steps
        guard = 0;
        while (!(mCh == 1 && mAge == 6) && guard < 200) begin
            applyStimulus(1'b0, 1'b0);
            guard++;
        end
        if (guard >= 200) begin
            miscompares++;
            $display("[TB] FAIL resetSetup bound expired");
        end
        applyStimulus(1'b1, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) checkOutput("rstCnt", i, 64'(bus.timeCnt[i]), 64'd0);
        checkOutput("rstDone", 0, 64'(bus.sweepDone), 64'd0);
        checkOutput("rstBusy", 0, 64'(bus.busyCh), 64'd0);
        sysVal = 30000;
        for (int k = 0; k < 18; k++) applyStimulus(1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("rstAlign", 0, 64'(bus.timeCnt[0]), 64'd1345);

        // Degenerate periods on channel 3
        cycleVal[3] = 0;
        repeat (150) applyStimulus(1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("degen0", 3, 64'(bus.timeCnt[3]), 64'd0);
        cycleVal[3] = 1;
        repeat (150) applyStimulus(1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("degen1", 3, 64'(bus.timeCnt[3]), 64'd0);
        cycleVal[3] = 5000;

        // Shrink channel 0 from 4096 to 100 while its counter reads 3000
        guard = 0;
        while (mCnt[0] != 3000 && guard < 5000) begin
            applyStimulus(1'b0, 1'b0);
            guard++;
        end
        if (guard >= 5000) begin
            miscompares++;
            $display("[TB] FAIL shrinkSetup bound expired");
        end
        cycleVal[0] = 100;
        wasWrite = (mActive && mCh == 0 && mAge == L - 1);
        applyStimulus(1'b0, 1'b0);
        @(posedge clk); #1;
        if (!wasWrite) checkOutput("shrinkWrap", 0, 64'(bus.timeCnt[0]), 64'd0);
        repeat (150) applyStimulus(1'b0, 1'b0);

        // Randomized soak: period changes, time jumps, resyncs and resets
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 99) == 0) cycleVal[$urandom_range(0, DEPTH - 1)] = pickCycle();
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 1) == 0) sysVal = (sysVal + 1) % TIME_MOD;
                else sysVal = longint'($urandom_range(0, 65535));
            end
            applyStimulus($urandom_range(0, 499) == 0, $urandom_range(0, 149) == 0);
        end

        @(posedge clk); #2;
        started = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
